// File: rtl/w_regwrite_arbiter.sv
// Write-back arbiter for the single GRF write port: in-order W-stage writes take
// priority, late results drain from a small FIFO, and pending writes are reported for hazards.
module w_regwrite_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p_we,
    input  logic [4:0]    p_a3,
    input  logic [31:0]   p_wd,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [4:0]    s_a3,
    input  logic [31:0]   s_wd,
    output logic          W_RegWrite,
    output logic [4:0]    W_A3,
    output logic [31:0]   W_RegWriteData,
    input  logic [4:0]    q_a1,
    input  logic [4:0]    q_a2,
    output logic          q_pend1,
    output logic          q_pend2,
    output logic [AW:0]   fifo_count
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [4:0]       a3_mem [DEPTH];
    logic [31:0]      wd_mem [DEPTH];
    // live = occupied and not superseded by a newer primary write
    logic [DEPTH-1:0] live;
    logic [DEPTH-1:0] kill_hit;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             p_valid;
    logic             push;
    logic             pop;
    logic             head_live;

    assign s_ready   = !reset && (fifo_count < FULL);
    assign p_valid   = p_we && (p_a3 != '0);
    assign push      = s_valid && s_ready && (s_a3 != '0);
    assign pop       = !p_valid && (fifo_count != '0);
    assign head_live = live[rd_ptr];

    always_comb begin
        kill_hit = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            kill_hit[i] = p_valid && live[i] && (a3_mem[i] == p_a3);
        end
    end

    always_comb begin
        q_pend1 = 1'b0;
        q_pend2 = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (live[i] && (a3_mem[i] == q_a1)) q_pend1 = 1'b1;
            if (live[i] && (a3_mem[i] == q_a2)) q_pend2 = 1'b1;
        end
        if (W_RegWrite && (W_A3 == q_a1)) q_pend1 = 1'b1;
        if (W_RegWrite && (W_A3 == q_a2)) q_pend2 = 1'b1;
        if (q_a1 == '0) q_pend1 = 1'b0;
        if (q_a2 == '0) q_pend2 = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            a3_mem[wr_ptr] <= s_a3;
            wd_mem[wr_ptr] <= s_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            live           <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count     <= '0;
            W_RegWrite     <= 1'b0;
            W_A3           <= '0;
            W_RegWriteData <= '0;
        end else begin
            // Push slot never equals pop slot (no push when full), so the per-bit
            // updates below cannot collide; a same-cycle primary to the same
            // register enqueues the entry already dead.
            live <= live & ~kill_hit;
            if (pop) begin
                live[rd_ptr] <= 1'b0;
                rd_ptr       <= rd_ptr + 1'b1;
            end
            if (push) begin
                live[wr_ptr] <= !(p_valid && (s_a3 == p_a3));
                wr_ptr       <= wr_ptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase

            if (p_valid) begin
                W_RegWrite     <= 1'b1;
                W_A3           <= p_a3;
                W_RegWriteData <= p_wd;
            end else if (pop) begin
                W_RegWrite <= head_live;
                if (head_live) begin
                    W_A3           <= a3_mem[rd_ptr];
                    W_RegWriteData <= wd_mem[rd_ptr];
                end
            end else begin
                W_RegWrite <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_w_regwrite_arbiter.sv
// Directed bench for w_regwrite_arbiter: expected GRF writes are queued as stimulus
// is driven and matched against the write port by a negedge monitor.
module tb_w_regwrite_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        p_we;
    logic [4:0]  p_a3;
    logic [31:0] p_wd;
    logic        s_valid;
    logic        s_ready;
    logic [4:0]  s_a3;
    logic [31:0] s_wd;
    logic        W_RegWrite;
    logic [4:0]  W_A3;
    logic [31:0] W_RegWriteData;
    logic [4:0]  q_a1;
    logic [4:0]  q_a2;
    logic        q_pend1;
    logic        q_pend2;
    logic [2:0]  fifo_count;

    typedef struct packed {
        logic [4:0]  a3;
        logic [31:0] wd;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         sec_q[$];
    logic [31:0] grf [32];
    int          checks = 0;
    int          errors = 0;
    int          accepted;

    w_regwrite_arbiter #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .reset(reset),
        .p_we(p_we), .p_a3(p_a3), .p_wd(p_wd),
        .s_valid(s_valid), .s_ready(s_ready), .s_a3(s_a3), .s_wd(s_wd),
        .W_RegWrite(W_RegWrite), .W_A3(W_A3), .W_RegWriteData(W_RegWriteData),
        .q_a1(q_a1), .q_a2(q_a2), .q_pend1(q_pend1), .q_pend2(q_pend2),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (W_RegWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_write: observed a3=%0d wd=%0h expected no write", W_A3, W_RegWriteData);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_a3", 32'(W_A3), 32'(e.a3));
                check("write_wd", W_RegWriteData, e.wd);
            end
            grf[W_A3] = W_RegWriteData;
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) grf[i] = '0;
        reset = 1'b1; p_we = 1'b0; p_a3 = '0; p_wd = '0;
        s_valid = 1'b0; s_a3 = '0; s_wd = '0; q_a1 = '0; q_a2 = '0;
        tick(); tick();
        check("rst_sready", 32'(s_ready), 32'd0);
        check("rst_regwrite", 32'(W_RegWrite), 32'd0);
        check("rst_a3", 32'(W_A3), 32'd0);
        check("rst_wd", W_RegWriteData, 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_sready", 32'(s_ready), 32'd1);

        // primary write, latency 1
        p_we = 1'b1; p_a3 = 5'd5; p_wd = 32'h11;
        exp_q.push_back('{a3: 5'd5, wd: 32'h11});
        tick();
        p_we = 1'b0;
        check("prim_regwrite", 32'(W_RegWrite), 32'd1);
        check("prim_a3", 32'(W_A3), 32'd5);
        check("prim_wd", W_RegWriteData, 32'h11);

        // single secondary through the FIFO
        s_valid = 1'b1; s_a3 = 5'd7; s_wd = 32'hAB;
        exp_q.push_back('{a3: 5'd7, wd: 32'hAB});
        tick();
        s_valid = 1'b0; q_a1 = 5'd7; q_a2 = 5'd7;
        #1;
        check("sec_count", 32'(fifo_count), 32'd1);
        check("sec_pend1_queued", 32'(q_pend1), 32'd1);
        check("sec_pend2_queued", 32'(q_pend2), 32'd1);
        check("sec_noprim_write", 32'(W_RegWrite), 32'd0);
        tick();
        check("sec_pop_regwrite", 32'(W_RegWrite), 32'd1);
        check("sec_pend1_inW", 32'(q_pend1), 32'd1);
        check("sec_pop_count", 32'(fifo_count), 32'd0);
        tick();
        check("sec_pend1_done", 32'(q_pend1), 32'd0);
        q_a2 = 5'd0;

        // primary burst fills FIFO, then drains in order
        accepted = 0;
        p_we = 1'b1; p_a3 = 5'd3;
        s_valid = 1'b1; s_a3 = 5'd10; s_wd = 32'h500;
        for (int k = 0; k < 6; k++) begin
            p_wd = 32'h300 + 32'(k);
            exp_q.push_back('{a3: 5'd3, wd: p_wd});
            if (s_valid && s_ready) begin
                sec_q.push_back('{a3: s_a3, wd: s_wd});
                accepted++;
            end
            tick();
            s_a3 = 5'(10 + accepted); s_wd = 32'h500 + 32'(accepted);
        end
        check("burst_accepted", 32'(accepted), 32'd4);
        check("burst_count_full", 32'(fifo_count), 32'd4);
        check("burst_sready_full", 32'(s_ready), 32'd0);
        p_we = 1'b0;
        while (sec_q.size() != 0) exp_q.push_back(sec_q.pop_front());
        for (int k = 0; k < 10; k++) begin
            if (s_valid && s_ready) begin
                exp_q.push_back('{a3: s_a3, wd: s_wd});
                accepted++;
                tick();
                s_valid = 1'b0;
            end else begin
                tick();
            end
        end
        check("drain_accepted", 32'(accepted), 32'd5);
        check("drain_sready", 32'(s_ready), 32'd1);
        check("drain_count", 32'(fifo_count), 32'd0);
        check("drain_exp_empty", 32'(exp_q.size()), 32'd0);

        // queued entry superseded by a later primary
        s_valid = 1'b1; s_a3 = 5'd9; s_wd = 32'h1;
        tick();
        s_valid = 1'b0; q_a1 = 5'd9;
        #1;
        check("kill_pend_before", 32'(q_pend1), 32'd1);
        p_we = 1'b1; p_a3 = 5'd9; p_wd = 32'h2;
        exp_q.push_back('{a3: 5'd9, wd: 32'h2});
        tick();
        p_we = 1'b0;
        check("kill_pend_primaryW", 32'(q_pend1), 32'd1);
        check("kill_count_held", 32'(fifo_count), 32'd1);
        tick();
        check("kill_pop_noWrite", 32'(W_RegWrite), 32'd0);
        check("kill_pend_after", 32'(q_pend1), 32'd0);
        check("kill_count_empty", 32'(fifo_count), 32'd0);
        check("kill_grf9", grf[9], 32'h2);

        // same-cycle primary and secondary to one register
        p_we = 1'b1; p_a3 = 5'd12; p_wd = 32'hC1;
        s_valid = 1'b1; s_a3 = 5'd12; s_wd = 32'hC2;
        exp_q.push_back('{a3: 5'd12, wd: 32'hC1});
        tick();
        p_we = 1'b0; s_valid = 1'b0; q_a1 = 5'd12;
        #1;
        check("same_count", 32'(fifo_count), 32'd1);
        check("same_pend_W", 32'(q_pend1), 32'd1);
        tick();
        check("same_pop_noWrite", 32'(W_RegWrite), 32'd0);
        check("same_pend_after", 32'(q_pend1), 32'd0);
        check("same_grf12", grf[12], 32'hC1);

        // writes to $0 are dropped
        p_we = 1'b1; p_a3 = 5'd0; p_wd = 32'hBEEF;
        s_valid = 1'b1; s_a3 = 5'd0; s_wd = 32'hDEAD;
        q_a1 = 5'd0;
        tick();
        p_we = 1'b0; s_valid = 1'b0;
        check("zero_count", 32'(fifo_count), 32'd0);
        check("zero_regwrite", 32'(W_RegWrite), 32'd0);
        check("zero_pend", 32'(q_pend1), 32'd0);
        tick();
        check("zero_regwrite2", 32'(W_RegWrite), 32'd0);

        // reset mid-operation discards queued entries
        p_we = 1'b1; p_a3 = 5'd4; p_wd = 32'h44;
        s_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_a3 = 5'(20 + k); s_wd = 32'h600 + 32'(k);
            exp_q.push_back('{a3: 5'd4, wd: 32'h44});
            tick();
        end
        check("prerst_count", 32'(fifo_count), 32'd3);
        p_we = 1'b0; s_valid = 1'b0; reset = 1'b1;
        #1;
        check("rst_mid_sready", 32'(s_ready), 32'd0);
        tick();
        check("rst_mid_count", 32'(fifo_count), 32'd0);
        check("rst_mid_regwrite", 32'(W_RegWrite), 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("rst_mid_regwrite_after", 32'(W_RegWrite), 32'd0);
        check("rst_mid_count_after", 32'(fifo_count), 32'd0);
        check("final_exp_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
